// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: two-stage valid/ready pipeline applying a selectable bitwise gate,
// with operand-equality flag, result popcount and a saturating equal-operand counter.
module logic_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    input  logic [2:0]                   op,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             y,
    output logic                         eq,
    output logic [$clog2(WIDTH+1)-1:0]   ones,
    input  logic                         cnt_clr,
    output logic [CNT_W-1:0]             match_cnt
);
    localparam int OW = $clog2(WIDTH+1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s1_valid_q, s1_valid_d, s1_eq_q, eq_d;
    logic [WIDTH-1:0] s1_y_q, y_d, y_q;
    logic             out_valid_q, out_valid_d, eq_q;
    logic [OW-1:0]    ones_d, ones_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s1_load, s2_load, out_hs;

    assign s2_load     = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready    = !s1_valid_q || s2_load;
    assign s1_load     = in_valid && in_ready;
    assign out_hs      = out_valid_q && out_ready;
    assign s1_valid_d  = s1_load || (s1_valid_q && !s2_load);
    assign out_valid_d = s2_load || (out_valid_q && !out_ready);
    assign eq_d        = &(a ~^ b);

    always_comb begin
        y_d = a;
        case (op)
            3'd0: y_d = a & b;
            3'd1: y_d = a | b;
            3'd2: y_d = a ^ b;
            3'd3: y_d = a ~^ b;
            3'd4: y_d = ~(a & b);
            3'd5: y_d = ~(a | b);
            3'd6: y_d = ~a;
            default: y_d = a;
        endcase
    end

    always_comb begin
        ones_d = '0;
        for (int i = 0; i < WIDTH; i++) ones_d = ones_d + OW'(s1_y_q[i]);
    end

    // clear takes priority over a coincident increment
    assign cnt_d = cnt_clr ? '0
                 : (out_hs && eq_q && cnt_q != CNT_MAX) ? cnt_q + 1'b1
                 : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_y_q      <= '0;
            s1_eq_q     <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            eq_q        <= 1'b0;
            ones_q      <= '0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
            if (s1_load) begin
                s1_y_q  <= y_d;
                s1_eq_q <= eq_d;
            end
            if (s2_load) begin
                y_q    <= s1_y_q;
                eq_q   <= s1_eq_q;
                ones_q <= ones_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign eq        = eq_q;
    assign ones      = ones_q;
    assign match_cnt = cnt_q;
endmodule

// File: tb/tb_logic_gate_pipe.sv
// tb_logic_gate_pipe: checks an 8-bit instance against vectors and a truth-table model,
// and a 1-bit/2-bit-counter instance against the gate tables and saturation rules.
module tb_logic_gate_pipe;
    typedef struct { logic [2:0] op; logic [7:0] a, b, y; logic eq; logic [3:0] ones; } vec_t;
    typedef struct { logic [7:0] y; logic eq; logic [3:0] ones; int t; } exp_t;

    logic clk, rst;
    logic iv8, rdy8, ov8, ordy8, eq8, clr8;
    logic [7:0] a8, b8, y8, mc8;
    logic [2:0] op8;
    logic [3:0] ones8;
    logic iv1, rdy1, ov1, a1, b1, y1, eq1, clr1;
    logic [2:0] op1;
    logic [0:0] ones1;
    logic [1:0] mc1;

    int total = 0, bad = 0, cyc = 0, popped = 0, mc = 0;
    bit lat_chk = 1;
    exp_t q[$];
    exp_t me;
    vec_t tbl[8];
    // y per op for operand pairs indexed {b,a}: 00,a-only,b-only,11
    logic [3:0] tt [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b1001, 4'b0111, 4'b0001, 4'b0101, 4'b1010};

    logic_gate_pipe #(.WIDTH(8), .CNT_W(8)) d8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8), .a(a8), .b(b8), .op(op8),
        .out_valid(ov8), .out_ready(ordy8), .y(y8), .eq(eq8), .ones(ones8),
        .cnt_clr(clr8), .match_cnt(mc8));

    logic_gate_pipe #(.WIDTH(1), .CNT_W(2)) d1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(rdy1), .a(a1), .b(b1), .op(op1),
        .out_valid(ov1), .out_ready(1'b1), .y(y1), .eq(eq1), .ones(ones1),
        .cnt_clr(clr1), .match_cnt(mc1));

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", n, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
        exp_t r;
        for (int i = 0; i < 8; i++) r.y[i] = tt[o][{z[i], x[i]}];
        r.eq = (x == z);
        r.ones = 4'($countones(r.y));
        r.t = 0;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && ov8 && ordy8) begin
            if (q.size() == 0) chk("spurious_out", 1, 0);
            else begin
                me = q.pop_front();
                chk("y", y8, me.y);
                chk("eq", eq8, me.eq);
                chk("ones", ones8, me.ones);
                if (lat_chk) chk("latency", cyc - me.t, 2);
                if (me.eq && mc != 255) mc++;
                popped++;
            end
        end
    end

    task automatic send8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z, input exp_t e);
        bit ok = 0;
        op8 = o; a8 = x; b8 = z; iv8 = 1;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (rdy8) begin
                e.t = cyc;
                q.push_back(e);
                ok = 1;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        iv8 = 0; a8 = 'x; b8 = 'x;
    endtask

    task automatic drain8();
        for (int k = 0; k < 40 && q.size() != 0; k++) begin
            @(negedge clk); #1;
        end
        chk("drain", q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic send1(input logic [2:0] o, input logic x, input logic z, input logic clr, input int ecnt);
        logic ey;
        ey = tt[o][{z, x}];
        op1 = o; a1 = x; b1 = z; iv1 = 1;
        @(negedge clk); chk("d1_in_ready", rdy1, 1);
        @(posedge clk); #1;
        iv1 = 0;
        @(negedge clk); chk("d1_early_valid", ov1, 0);
        @(negedge clk);
        chk("d1_valid", ov1, 1);
        chk("d1_y", y1, ey);
        chk("d1_eq", eq1, x == z);
        chk("d1_ones", ones1, ey);
        if (clr) clr1 = 1;
        @(negedge clk);
        clr1 = 0;
        if (ecnt >= 0) chk("d1_match_cnt", mc1, ecnt);
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        logic [7:0] x, z, hold;
        logic [2:0] o;
        int p0;
        rst = 1; iv8 = 0; ordy8 = 1; clr8 = 0; a8 = 0; b8 = 0; op8 = 0;
        iv1 = 0; a1 = 0; b1 = 0; op1 = 0; clr1 = 0;
        tbl[0] = '{3'd3, 8'hA5, 8'hA5, 8'hFF, 1'b1, 4'd8};
        tbl[1] = '{3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, 4'd2};
        tbl[2] = '{3'd1, 8'hF0, 8'h0F, 8'hFF, 1'b0, 4'd8};
        tbl[3] = '{3'd2, 8'hC3, 8'h5A, 8'h99, 1'b0, 4'd4};
        tbl[4] = '{3'd4, 8'hFF, 8'hFF, 8'h00, 1'b1, 4'd0};
        tbl[5] = '{3'd5, 8'h00, 8'h00, 8'hFF, 1'b1, 4'd8};
        tbl[6] = '{3'd6, 8'h0F, 8'h33, 8'hF0, 1'b0, 4'd4};
        tbl[7] = '{3'd7, 8'h81, 8'h81, 8'h81, 1'b1, 4'd2};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", ov8, 0);
        chk("rst_y", y8, 0);
        chk("rst_eq", eq8, 0);
        chk("rst_ones", ones8, 0);
        chk("rst_match_cnt", mc8, 0);
        chk("rst_d1_out_valid", ov1, 0);
        chk("rst_d1_match_cnt", mc1, 0);
        rst = 0;
        @(negedge clk); chk("in_ready_after_rst", rdy8, 1);
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            e.y = tbl[i].y; e.eq = tbl[i].eq; e.ones = tbl[i].ones; e.t = 0;
            send8(tbl[i].op, tbl[i].a, tbl[i].b, e);
        end
        drain8();

        for (int k = 0; k < 8; k++)
            for (int i = 0; i < 4; i++) send1(3'(k), i[0], i[1], 1'b0, -1);

        @(posedge clk); #1; clr1 = 1;
        @(posedge clk); #1; clr1 = 0;
        chk("d1_cleared", mc1, 0);
        for (int k = 1; k <= 5; k++) send1(3'd3, 1'b1, 1'b1, 1'b0, k > 3 ? 3 : k);
        send1(3'd0, 1'b1, 1'b0, 1'b0, 3);
        send1(3'd0, 1'b1, 1'b1, 1'b1, 0);
        send1(3'd7, 1'b0, 1'b0, 1'b0, 1);

        lat_chk = 0; ordy8 = 0; p0 = popped;
        fork
            for (int k = 0; k < 5; k++) begin
                o = 3'($urandom_range(0, 7)); x = 8'($urandom);
                z = (k % 2 == 1) ? x : 8'($urandom);
                send8(o, x, z, model(o, x, z));
            end
            begin
                repeat (3) @(negedge clk);
                chk("bp_in_ready_low", rdy8, 0);
                chk("bp_accepted", q.size(), 2);
                hold = y8;
                repeat (2) begin
                    @(negedge clk);
                    chk("bp_in_ready_low", rdy8, 0);
                    chk("bp_out_valid", ov8, 1);
                    chk("bp_y_stable", y8, hold);
                end
                @(posedge clk); #1;
                ordy8 = 1;
            end
        join
        drain8();
        chk("bp_count", popped - p0, 5);

        lat_chk = 1;
        clr8 = 1;
        @(posedge clk); #1;
        clr8 = 0; mc = 0; p0 = popped;
        for (int k = 0; k < 100; k++) begin
            o = 3'($urandom_range(0, 7)); x = 8'($urandom);
            z = ($urandom_range(0, 9) < 3) ? x : 8'($urandom);
            send8(o, x, z, model(o, x, z));
        end
        drain8();
        chk("stream_count", popped - p0, 100);
        chk("stream_match_cnt", mc8, mc);

        ordy8 = 0;
        send8(3'd1, 8'h3C, 8'h3C, model(3'd1, 8'h3C, 8'h3C));
        send8(3'd2, 8'h11, 8'h11, model(3'd2, 8'h11, 8'h11));
        #2 rst = 1;
        #1;
        chk("arst_out_valid", ov8, 0);
        chk("arst_y", y8, 0);
        chk("arst_eq", eq8, 0);
        chk("arst_ones", ones8, 0);
        chk("arst_match_cnt", mc8, 0);
        q.delete(); mc = 0; ordy8 = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk); chk("arst_in_ready", rdy8, 1);
        chk("arst_no_stale", ov8, 0);
        @(posedge clk); #1;
        send8(3'd3, 8'hA5, 8'hA5, model(3'd3, 8'hA5, 8'hA5));
        drain8();
        chk("arst_match_after", mc8, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
